// File: rtl/t00_period_timer_ctrl.sv
// rtl/t00_period_timer_ctrl.sv - period/repetition sequencer driving a t00_flex_counter
module t00_period_timer_ctrl #(
  parameter int NUM_BITS = 4,
  parameter int REP_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                pause,
  input  logic [NUM_BITS-1:0] period,
  input  logic [REP_BITS-1:0] reps,
  input  logic                cnt_rollover_flag,
  output logic                cnt_clear,
  output logic                cnt_enable,
  output logic [NUM_BITS-1:0] cnt_rollover_val,
  output logic                tick,
  output logic [REP_BITS-1:0] rep_count,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [NUM_BITS-1:0] r_period_q;
  logic [REP_BITS-1:0] r_reps_q;
  logic [REP_BITS-1:0] r_rep_count;
  logic                r_tick;

  logic                w_start_ok;
  logic                w_wrap;
  logic                w_final;
  logic [REP_BITS-1:0] w_rep_next;

  // A zero period would never produce a rollover, so such starts are dropped.
  assign w_start_ok = start && (period != '0);

  // A wrap only counts when the counter really advanced past its top value this
  // cycle; stop and pause both win over a pending flag.
  assign w_wrap     = (r_state == S_RUN) && cnt_rollover_flag && !stop && !pause;
  assign w_rep_next = r_rep_count + 1'b1;
  assign w_final    = w_wrap && (r_reps_q != '0) && (w_rep_next == r_reps_q);

  assign cnt_rollover_val = r_period_q;
  assign tick             = r_tick;
  assign rep_count        = r_rep_count;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; priority is stop, then pause, then the final wrap.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (stop)         w_state_next = S_IDLE;
        else if (pause)   w_state_next = S_PAUSE;
        else if (w_final) w_state_next = S_DONE;
      end
      S_PAUSE: begin
        if (stop)        w_state_next = S_IDLE;
        else if (!pause) w_state_next = S_RUN;
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Counter controls and status; pause drops the enable in the same cycle it is seen.
  always_comb begin
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_IDLE: cnt_clear = 1'b1;
      S_RUN: begin
        cnt_enable = !pause;
        busy       = 1'b1;
      end
      S_PAUSE: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: cnt_clear = 1'b1;
    endcase
  end

  // Run parameters, completed-period count and the registered tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_period_q  <= '0;
      r_reps_q    <= '0;
      r_rep_count <= '0;
      r_tick      <= 1'b0;
    end else begin
      r_tick <= w_wrap;
      if ((r_state == S_IDLE) && w_start_ok) begin
        r_period_q  <= period;
        r_reps_q    <= reps;
        r_rep_count <= '0;
      end else if (w_wrap) begin
        r_rep_count <= w_rep_next;
      end
    end
  end

endmodule

// File: tb/tb_t00_period_timer_ctrl.sv
// tb/tb_t00_period_timer_ctrl.sv - directed bench with a flex counter model downstream
module tb_t00_period_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] period = 4'd0;
  logic [7:0] reps = 8'd0;
  logic       cnt_rollover_flag;
  logic       cnt_clear;
  logic       cnt_enable;
  logic [3:0] cnt_rollover_val;
  logic       tick;
  logic [7:0] rep_count;
  logic       busy;
  logic       done;

  logic [3:0] count_out = 4'd0;
  logic       flag_r = 1'b0;
  logic [3:0] cnt_next;

  int n_checks = 0;
  int n_pass = 0;

  logic [31:0] tick_mask;
  logic [31:0] done_mask;

  always #5 clk = ~clk;

  t00_period_timer_ctrl #(.NUM_BITS(4), .REP_BITS(8)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .pause(pause),
    .period(period),
    .reps(reps),
    .cnt_rollover_flag(cnt_rollover_flag),
    .cnt_clear(cnt_clear),
    .cnt_enable(cnt_enable),
    .cnt_rollover_val(cnt_rollover_val),
    .tick(tick),
    .rep_count(rep_count),
    .busy(busy),
    .done(done)
  );

  // Downstream flex counter: counts 1..rollover_val, flag registered with the count.
  assign cnt_next = (count_out == cnt_rollover_val) ? 4'd1 : count_out + 4'd1;
  assign cnt_rollover_flag = flag_r;

  always_ff @(posedge clk) begin
    if (cnt_clear) begin
      count_out <= 4'd0;
      flag_r    <= 1'b0;
    end else if (cnt_enable) begin
      count_out <= cnt_next;
      flag_r    <= (cnt_next == cnt_rollover_val);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench at the falling edge after the accepting edge E0.
  task automatic do_start(input logic [3:0] p, input logic [7:0] r);
    period = p;
    reps   = r;
    start  = 1'b1;
    step(1);
    start  = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step(1);
    stop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step(2);
    rst = 1'b0;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_clear", cnt_clear, 1);
    check_eq("rst_enable", cnt_enable, 0);
    check_eq("rst_rval", cnt_rollover_val, 0);
    check_eq("rst_repcnt", rep_count, 0);
    check_eq("rst_tick", tick, 0);
    check_eq("rst_done", done, 0);

    // Reset for two edges in the middle of a run
    do_start(4'd5, 8'd0);
    step(3);
    check_eq("run_busy", busy, 1);
    check_eq("run_count3", count_out, 3);
    rst = 1'b1;
    step(1);
    check_eq("mrst_busy", busy, 0);
    check_eq("mrst_clear", cnt_clear, 1);
    check_eq("mrst_enable", cnt_enable, 0);
    check_eq("mrst_rval", cnt_rollover_val, 0);
    check_eq("mrst_repcnt", rep_count, 0);
    check_eq("mrst_tick", tick, 0);
    step(1);
    rst = 1'b0;
    check_eq("mrst_count0", count_out, 0);

    // period=4 reps=3: ticks after E5, E9, E13; done with the third
    tick_mask = '0;
    done_mask = '0;
    do_start(4'd4, 8'd3);
    check_eq("p4_rval", cnt_rollover_val, 4);
    for (int k = 1; k <= 16; k++) begin
      step(1);
      tick_mask[k] = tick;
      done_mask[k] = done;
      if (k == 4)  check_eq("p4_count_at_P", count_out, 4);
      if (k == 13) check_eq("p4_repcnt", rep_count, 3);
      if (k == 14) begin
        check_eq("p4_busy_after", busy, 0);
        check_eq("p4_idle_clear", cnt_clear, 1);
      end
    end
    check_eq("p4_ticks", tick_mask, 32'h0000_2220);
    check_eq("p4_done", done_mask, 32'h0000_2000);

    // period=5 reps=0, pause at count 3 for six cycles
    do_start(4'd5, 8'd0);
    step(3);
    check_eq("pz_count3", count_out, 3);
    pause = 1'b1;
    #1;
    check_eq("pz_enable_same", cnt_enable, 0);
    tick_mask = '0;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      tick_mask[k] = tick;
    end
    check_eq("pz_hold_count", count_out, 3);
    check_eq("pz_enable", cnt_enable, 0);
    check_eq("pz_busy", busy, 1);
    check_eq("pz_no_tick", tick_mask, 0);
    pause = 1'b0;
    tick_mask = '0;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      tick_mask[k] = tick;
      if (k == 2) check_eq("pz_count4", count_out, 4);
    end
    check_eq("pz_resume_tick", tick_mask, 32'h0000_0010);
    do_stop();
    check_eq("pz_stopped", busy, 0);

    // Stop on the final-period flag: no tick, no done, rep_count holds
    do_start(4'd3, 8'd2);
    step(6);
    check_eq("st_flag", cnt_rollover_flag, 1);
    check_eq("st_rep1", rep_count, 1);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    check_eq("st_busy", busy, 0);
    check_eq("st_tick", tick, 0);
    check_eq("st_done", done, 0);
    check_eq("st_repcnt", rep_count, 1);
    check_eq("st_clear", cnt_clear, 1);
    step(1);
    check_eq("st_count0", count_out, 0);
    check_eq("st_tick2", tick, 0);
    check_eq("st_done2", done, 0);

    // Zero period ignored; mid-run start ignored
    do_start(4'd0, 8'd0);
    check_eq("z_busy", busy, 0);
    check_eq("z_clear", cnt_clear, 1);
    tick_mask = '0;
    do_start(4'd6, 8'd0);
    for (int k = 1; k <= 20; k++) begin
      step(1);
      tick_mask[k] = tick;
      if (k == 2) begin
        period = 4'd2;
        start  = 1'b1;
      end
      if (k == 3) start = 1'b0;
    end
    check_eq("ms_rval", cnt_rollover_val, 6);
    check_eq("ms_ticks", tick_mask, 32'h0008_2080);
    do_stop();

    // Reset pulse between edges has no effect
    tick_mask = '0;
    do_start(4'd3, 8'd0);
    for (int k = 1; k <= 14; k++) begin
      step(1);
      tick_mask[k] = tick;
      if (k == 5) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end
    check_eq("gl_busy", busy, 1);
    check_eq("gl_ticks", tick_mask, 32'h0000_2490);
    check_eq("gl_repcnt", rep_count, 4);
    do_stop();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/t00_period_timer_ctrl.md
Name: t00_period_timer_ctrl

Overview:
Control stage that sits directly upstream of t00_flex_counter. It programs and sequences the counter's clear, count_enable and rollover_val inputs. It consumes the counter's rollover_flag to count completed periods, emitting a one-cycle tick per period and a done pulse after a programmed number of repetitions. It also provides start, stop and pause control to the rest of the design.

Parameters:
NUM_BITS, 4, width of period and of the counter's rollover_val/count_out
REP_BITS, 8, width of repetition target and repetition counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin a run; sampled only in IDLE
stop  input  1  abort the run, return to IDLE
pause  input  1  level; hold the counter while high (RUN/PAUSE only)
period  input  NUM_BITS  rollover value; latched on accepted start
reps  input  REP_BITS  periods per run; 0 = run until stop; latched on accepted start
cnt_rollover_flag  input  1  rollover_flag from the downstream t00_flex_counter
cnt_clear  output  1  to counter clear
cnt_enable  output  1  to counter count_enable
cnt_rollover_val  output  NUM_BITS  to counter rollover_val (latched period)
tick  output  1  one-cycle pulse after each completed period
rep_count  output  REP_BITS  completed periods in the current run
busy  output  1  high in RUN or PAUSE
done  output  1  one-cycle pulse when reps periods have completed

Behaviour:
- Reset is synchronous and active-high. rst is sampled only at a clk rising edge and has priority over every other input.
- Reset values: state=IDLE, period_q=0, reps_q=0, rep_count=0, tick=0, done=0, busy=0.
- Derived outputs during reset: cnt_clear=1, cnt_enable=0, cnt_rollover_val=0.
- States are IDLE, RUN, PAUSE, DONE. Outputs decode combinationally from state, except tick and rep_count, which are registered.
- IDLE: cnt_clear=1, cnt_enable=0, which holds the counter at 0. On start=1 with period!=0:
  - latch period_q and reps_q;
  - clear rep_count;
  - go to RUN.
- IDLE, ignored starts: start with period==0 is ignored and the state stays IDLE.
- RUN: cnt_clear=0, cnt_enable=1.
- Wrap event: cnt_rollover_flag=1 while in RUN with no stop and no pause in that cycle. On a wrap event:
  - rep_count increments (modulo 2^REP_BITS when reps_q=0);
  - tick=1 in the next cycle.
- Final wrap: if a wrap event occurs with reps_q!=0 and rep_count+1==reps_q, go to DONE. tick and done are both high in the DONE cycle.
- Timing for start sampled at edge E0: count reaches P at edge E0+P, the first wrap is at E0+P+1, and the first tick is high in the cycle after E0+P+1. Subsequent ticks follow every P cycles.
- Period 1: the flag stays high continuously, so a tick occurs every cycle.
- RUN with pause=1: go to PAUSE, with cnt_enable=0 in that same cycle. No wrap event is taken, even if the flag is high.
- PAUSE: cnt_enable=0, cnt_clear=0, so the counter and its flag hold. When pause=0, return to RUN (enable resumes next cycle).
- DONE: cnt_enable=0, cnt_clear=0, done=1 for one cycle, then unconditionally go to IDLE. start is ignored in DONE.
- stop=1 in RUN or PAUSE: go to IDLE next edge.
  - No tick, no rep_count increment, no done, even on a final-wrap cycle.
  - rep_count holds its value until the next accepted start.
- Priority: rst > stop > pause > wrap event.
- start while busy is ignored; period and reps are not re-latched.
- Changing period or reps mid-run has no effect. cnt_rollover_val = period_q at all times.

Test Plan:
- rst=1 for 2 edges during RUN, period=5 → after the edge: state IDLE, cnt_clear=1, cnt_enable=0, cnt_rollover_val=0, rep_count=0, tick=0, busy=0; counter count_out=0 one edge later.
- With a real t00_flex_counter attached, period=4, reps=3, start at E0 → ticks in the cycles after E5, E9 and E13; done=1 with the third tick; rep_count=3; busy=0 and IDLE after E14.
- period=5, reps=0, pause=1 when count_out=3 for 6 cycles → count_out holds 3, cnt_enable=0, no tick; after pause drops, the next tick arrives 3 cycles later (count 4, 5, then wrap).
- stop=1 in the cycle where the flag is high on the final period (period=3, reps=2) → IDLE next edge, no tick, no done, rep_count=1, count_out=0 one edge later.
- start with period=0 → stays IDLE, busy=0. Then start with period=6, and mid-run pulse start with period=2 → cnt_rollover_val stays 6 and tick spacing stays 6.
- rst raised and dropped between two clock edges mid-run → no state change; the run continues and the tick schedule is unchanged.
